instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-register, shared-data-bus CPU. Owns the 16-bit program counter and instruction register, and drives the one-hot register read/write enables and the memory control lines (ce/wre/rst). All data moves over the shared 8-bit data bus and the 16-bit address bus formed from register pairs. It replaces the free-running control stub and is the only master of those enables.

## Interface
- No parameters; widths fixed by the CPU (8 registers, 8-bit data, 16-bit address).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_in  in  8  data bus as seen by the sequencer (memory read data, register output)
- addr_in  in  16  address bus as driven by a selected register pair
- regs_rdata  out  8  one-hot: register i drives data bus
- regs_wdata  out  8  one-hot: register i loads from data bus
- regs_raddr  out  8  one-hot: register i drives its half of address bus
- regs_waddr  out  8  always 0 (reserved)
- mem_ce, mem_wre, mem_rst  out  1 each  memory chip enable, write enable, memory reset
- pc_oe  out  1  PC drives address bus
- pc_out  out  16  PC value
- halted  out  1  sequencer stopped by HLT

## Operation
- Opcode byte: [7:6] class, [5:3] d, [2:0] s. Pair p = s[2:1]: high byte reg 2p, low byte reg 2p+1; s[0] ignored.
- 00 MOV rd,rs: regs_rdata[s], regs_wdata[d].
- 01 LD rd,[p]: regs_raddr[2p]|[2p+1], mem read; next cycle regs_wdata[d].
- 10 ST [p],rd: regs_raddr pair, regs_rdata[d], mem_ce=1, mem_wre=1.
- 11 000 LDI rs,imm: read byte at PC, write to reg s, PC+1.
- 11 001 JMP p: PC <= addr_in while pair drives address bus.
- 11 111 HLT: enter HALT. All other 11 xxx: NOP.
- States: INIT -> FETCH -> DECODE -> EXEC -> (WB for LD/LDI) -> FETCH; HALT absorbing until rst.
- INIT: mem_rst=1, all else idle; one cycle.
- FETCH: pc_oe=1, mem_ce=1, mem_wre=0.
- DECODE: IR <= data_in; PC <= PC+1.
- EXEC: per opcode above. LDI issues read at PC with pc_oe=1. JMP loads PC.
- WB: regs_wdata[target]=1, memory data valid on bus.
- Outside listed cycles every enable is 0. At most one regs_rdata bit set, at most one regs_wdata bit set, pc_oe and regs_raddr never both nonzero.
- PC arithmetic: 16-bit modulo, 0xFFFF+1 = 0x0000 (fetch and LDI increment).

## Timing
- Memory is synchronous: read issued in cycle N (ce=1, wre=0) returns valid data_in in N+1. Write commits at the edge ending the ce&wre cycle.
- Cycles per instruction: MOV/ST/JMP/NOP/HLT 3, LD/LDI 4.
- Reset values (asserted immediately on rst, held while high): state INIT, PC=0x0000, IR=0x00, all regs_* 0, mem_ce=0, mem_wre=0, mem_rst=1, pc_oe=0, halted=0.
- rst mid-instruction: aborts; no partial register write occurs after rst asserts. First fetch after release is at 0x0000, one cycle after INIT.
- HALT: halted=1 from the cycle after HLT EXEC; all enables 0; PC frozen at HLT address+1.
- JMP to own address: legal, loops forever.

## Configuration
- SEQ_JZ_EN defined: one-bit zero flag Z, reset 0. Updated to (data_in==0) on every cycle with a regs_wdata bit set. Opcode 11 010 sss = JZ p: PC <= addr_in if Z=1, else no change. 3 cycles either way.
- Undefined: no Z flag; 11 010 decodes as NOP.

## Test plan
- Reset: hold rst 3 cycles mid-LD -> mem_rst=1, pc_out=0x0000, all enables 0. First FETCH with pc_oe=1 two cycles after release.
- LDI r1,0x5A then MOV r4,r1 -> WB cycle regs_wdata=0x02. Next EXEC regs_rdata=0x02 and regs_wdata=0x10. PC ends 0x0003.
- ST [p1],r0 with r2:r3=0x1234 -> EXEC regs_raddr=0x0C, regs_rdata=0x01, mem_ce=1, mem_wre=1. LD r5,[p1] -> data returned one cycle later, regs_wdata=0x20.
- JMP p0 with r0:r1=0xFFFF, then NOP at 0xFFFF -> next fetch address 0x0000 (wrap).
- HLT at 0x0010 -> halted=1, pc_out=0x0011 stable 20 cycles, no enables. rst recovers.
- SEQ_JZ_EN: LDI r0,0x00; JZ p2 -> taken. LDI r0,0x01; JZ -> not taken, PC+1. Without macro, both leave PC sequential.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and the register file / memory datapath.
// The master side is the sequencer; the slave side is the datapath it controls.
interface instr_sequencer_if;
  logic [7:0]  data_in;
  logic [15:0] addr_in;
  logic [7:0]  regs_rdata;
  logic [7:0]  regs_wdata;
  logic [7:0]  regs_raddr;
  logic [7:0]  regs_waddr;
  logic        mem_ce;
  logic        mem_wre;
  logic        mem_rst;
  logic        pc_oe;
  logic [15:0] pc_out;
  logic        halted;

  modport master (
    input  data_in, addr_in,
    output regs_rdata, regs_wdata, regs_raddr, regs_waddr,
    output mem_ce, mem_wre, mem_rst, pc_oe, pc_out, halted
  );

  modport slave (
    output data_in, addr_in,
    input  regs_rdata, regs_wdata, regs_raddr, regs_waddr,
    input  mem_ce, mem_wre, mem_rst, pc_oe, pc_out, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer owning PC and IR for the 8-register shared-bus CPU.
// Define SEQ_JZ_EN to add a zero flag and the JZ instruction (opcode 11 010 sss).
module instr_sequencer (
  input  logic clk,
  input  logic rst,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [7:0]  ir;

  logic [7:0]  rdata, wdata, raddr;
  logic        ce, wre, mrst, pc_oe, halted;

  logic [1:0]  cls;
  logic [2:0]  fld_d, fld_s;
  logic [7:0]  pair_mask;

  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    one_hot = 8'h01 << idx;
  endfunction

  assign cls       = ir[7:6];
  assign fld_d     = ir[5:3];
  assign fld_s     = ir[2:0];
  assign pair_mask = one_hot({fld_s[2:1], 1'b0}) | one_hot({fld_s[2:1], 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      pc    <= 16'h0000;
      ir    <= 8'h00;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == DECODE)
        ir <= bus.data_in;
    end
  end

`ifdef SEQ_JZ_EN
  logic z_flag;

  // Z tracks whatever value was last written into any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      z_flag <= 1'b0;
    else if (|wdata)
      z_flag <= (bus.data_in == 8'h00);
  end
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    rdata      = 8'h00;
    wdata      = 8'h00;
    raddr      = 8'h00;
    ce         = 1'b0;
    wre        = 1'b0;
    mrst       = 1'b0;
    pc_oe      = 1'b0;
    halted     = 1'b0;
    case (state)
      INIT: begin
        mrst       = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        pc_oe      = 1'b1;
        ce         = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        pc_next    = pc + 16'd1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (cls)
          2'b00: begin
            rdata = one_hot(fld_s);
            wdata = one_hot(fld_d);
          end
          2'b01: begin
            raddr      = pair_mask;
            ce         = 1'b1;
            state_next = WB;
          end
          2'b10: begin
            raddr = pair_mask;
            rdata = one_hot(fld_d);
            ce    = 1'b1;
            wre   = 1'b1;
          end
          default: begin
            // Class 11 uses the d field as a sub-opcode.
            case (fld_d)
              3'b000: begin
                pc_oe      = 1'b1;
                ce         = 1'b1;
                pc_next    = pc + 16'd1;
                state_next = WB;
              end
              3'b001: begin
                raddr   = pair_mask;
                pc_next = bus.addr_in;
              end
`ifdef SEQ_JZ_EN
              3'b010: begin
                raddr = pair_mask;
                if (z_flag)
                  pc_next = bus.addr_in;
              end
`endif
              3'b111: state_next = HALT;
              default: ;
            endcase
          end
        endcase
      end
      WB: begin
        wdata      = (cls == 2'b11) ? one_hot(fld_s) : one_hot(fld_d);
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  assign bus.regs_rdata = rdata;
  assign bus.regs_wdata = wdata;
  assign bus.regs_raddr = raddr;
  assign bus.regs_waddr = 8'h00;
  assign bus.mem_ce     = ce;
  assign bus.mem_wre    = wre;
  assign bus.mem_rst    = mrst;
  assign bus.pc_oe      = pc_oe;
  assign bus.pc_out     = pc;
  assign bus.halted     = halted;

endmodule
